pipe_stage_reg: RTL

Parametrised pipeline stage register replacing the fixed enable-only inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB). Carries an arbitrary-width payload with a valid/ready handshake, synchronous flush (bubble insertion) and an optional 2-entry skid buffer. The skid buffer gives full throughput with a registered `in_ready`. Sits between any two pipeline stages; hazard logic drives `flush` and back-pressure through `out_ready`.

---
 rtl/pipe_stage_reg_pkg.sv | 13 +
 rtl/pipe_stage_reg_if.sv | 25 ++
 rtl/pipe_stage_reg_slot.sv | 36 +++
 rtl/pipe_stage_reg.sv | 134 +++++++++++++
 4 files changed

// File: rtl/pipe_stage_reg_pkg.sv
// Shared types and constants for the pipeline stage register family.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } pipe_state_t;

    // All-zero word decodes as a NOP in the instruction fields of a payload.
    localparam logic [31:0] PIPE_BUBBLE_NOP = 32'h0000_0000;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle of one pipeline stage register: upstream side, downstream side, flush and occupancy.
interface pipe_stage_reg_if #(
    parameter int DATA_W = 64
) ();

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        count;

    modport master (
        output in_valid, in_data, flush, out_ready,
        input  in_ready, out_valid, out_data, count
    );

    modport slave (
        input  in_valid, in_data, flush, out_ready,
        output in_ready, out_valid, out_data, count
    );

endinterface

// File: rtl/pipe_stage_reg_slot.sv
// One storage slot: payload register plus a valid flag; only the flag is reset.
module pipe_slot #(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_load,
    input  logic              i_clear,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_load) begin
            r_data <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with flush and an optional 2-entry skid buffer.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int              DATA_W = 64,
    parameter bit              SKID   = 1'b1,
    parameter logic [DATA_W-1:0] BUBBLE = {DATA_W{1'b0}}
) (
    input logic             clk,
    input logic             reset,
    pipe_stage_reg_if.slave bus
);

    pipe_state_t       r_state;
    pipe_state_t       w_stateNext;
    logic              w_push;
    logic              w_pop;
    logic              w_inReady;
    logic              w_mainValid;
    logic              w_skidValid;
    logic              w_mainLoad;
    logic              w_mainClear;
    logic              w_mainFromSkid;
    logic [DATA_W-1:0] w_mainIn;
    logic [DATA_W-1:0] w_mainData;
    logic [DATA_W-1:0] w_skidData;

    assign w_pop  = w_mainValid & bus.out_ready;
    assign w_push = bus.in_valid & w_inReady;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Flush wins over any accept or pop in the same cycle.
    always_comb begin
        w_stateNext    = r_state;
        w_mainLoad     = 1'b0;
        w_mainClear    = 1'b0;
        w_mainFromSkid = 1'b0;
        if (bus.flush) begin
            w_stateNext = EMPTY;
            w_mainClear = 1'b1;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_push) begin
                        w_stateNext = ONE;
                        w_mainLoad  = 1'b1;
                    end
                end
                ONE: begin
                    if (w_push && w_pop) begin
                        w_mainLoad = 1'b1;
                    end else if (w_push) begin
                        w_stateNext = TWO;
                    end else if (w_pop) begin
                        w_stateNext = EMPTY;
                        w_mainClear = 1'b1;
                    end
                end
                TWO: begin
                    if (w_pop) begin
                        w_stateNext    = ONE;
                        w_mainLoad     = 1'b1;
                        w_mainFromSkid = 1'b1;
                    end
                end
                default: begin
                    w_stateNext = EMPTY;
                    w_mainClear = 1'b1;
                end
            endcase
        end
    end

    assign w_mainIn = w_mainFromSkid ? w_skidData : bus.in_data;

    pipe_slot #(.DATA_W(DATA_W)) mainSlot (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_mainLoad),
        .i_clear (w_mainClear),
        .i_data  (w_mainIn),
        .o_valid (w_mainValid),
        .o_data  (w_mainData)
    );

    generate
        if (SKID) begin : g_skid
            logic r_inReady;
            logic w_skidLoad;
            logic w_skidClear;

            assign w_skidLoad  = !bus.flush && (r_state == ONE) && w_push && !w_pop;
            assign w_skidClear = bus.flush || ((r_state == TWO) && w_pop);

            pipe_slot #(.DATA_W(DATA_W)) skidSlot (
                .clk     (clk),
                .reset   (reset),
                .i_load  (w_skidLoad),
                .i_clear (w_skidClear),
                .i_data  (bus.in_data),
                .o_valid (w_skidValid),
                .o_data  (w_skidData)
            );

            // Registered ready: looks one state ahead so it never depends on out_ready.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_inReady <= 1'b1;
                end else begin
                    r_inReady <= (w_stateNext != TWO);
                end
            end

            assign w_inReady = r_inReady;
        end else begin : g_noSkid
            assign w_skidValid = 1'b0;
            assign w_skidData  = {DATA_W{1'b0}};
            assign w_inReady   = !w_mainValid | bus.out_ready;
        end
    endgenerate

    assign bus.in_ready  = w_inReady;
    assign bus.out_valid = w_mainValid;
    assign bus.out_data  = w_mainValid ? w_mainData : BUBBLE;
    assign bus.count     = {1'b0, w_mainValid} + {1'b0, w_skidValid};

endmodule
